cp0_gen: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core, placed beside the M stage. It holds SR, Cause, EPC, BadVAddr, PRId and an optional Count/Compare timer. It arbitrates external interrupts (configurable line count), the timer interrupt and M-stage exceptions into a single take-exception request, and records the victim PC and fault address.

---
 rtl/cp0_gen.sv | 156 +++++++++++++++
 tb/tb_cp0_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_gen.sv
// Coprocessor-0 beside the M stage: SR/Cause/EPC/BadVAddr/PRId, interrupt and exception arbitration.
// Optional Count/Compare timer built when CP0_TIMER_EN is defined.
module cp0_gen #(
    parameter int          INT_NUM  = 6,
    parameter logic [31:0] PRID     = 32'h0000_4D50,
    parameter int          TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               eret_in,
    input  logic               bd_in,
    input  logic [4:0]         exc_code_in,
    input  logic [4:0]         reg_num,
    input  logic [INT_NUM-1:0] int_req,
    input  logic [31:0]        wdata,
    input  logic [31:0]        vpc,
    input  logic [31:0]        bad_vaddr_in,
    output logic [31:0]        rdata,
    output logic [31:0]        epc_out,
    output logic               req,
    output logic               timer_irq
);

    logic [INT_NUM-1:0] sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [INT_NUM-1:0] cause_ip;
    logic [4:0]         cause_exc;
    logic [31:0]        epc;
    logic [31:0]        bad_vaddr;

    logic [INT_NUM-1:0] ip_next;
    logic               int_take;
    logic               exc_take;
    logic               mtc0;
    logic [31:0]        sr_word;
    logic [31:0]        cause_word;

    // The timer flag shares the top interrupt line with the external request.
    always_comb begin
        ip_next = int_req;
        ip_next[INT_NUM-1] = int_req[INT_NUM-1] | timer_irq;
    end

    assign int_take = (|(ip_next & sr_im)) && sr_ie && !sr_exl;
    assign exc_take = (exc_code_in != 5'd0) && !sr_exl;
    assign req      = int_take | exc_take;
    assign mtc0     = we && !req;

    assign sr_word    = ({{(32-INT_NUM){1'b0}}, sr_im} << 10) | {30'd0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 31'd0} | ({{(32-INT_NUM){1'b0}}, cause_ip} << 10)
                      | {25'd0, cause_exc, 2'd0};
    assign epc_out    = (we && reg_num == 5'd14) ? wdata : epc;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic [7:0]  presc;
    logic        timer_flag;
    logic        tick;
    logic        count_wr;
    logic        cmp_wr;

    assign tick     = (presc == 8'(TICK_DIV - 1));
    assign count_wr = mtc0 && (reg_num == 5'd9);
    assign cmp_wr   = mtc0 && (reg_num == 5'd11);

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            compare    <= '0;
            presc      <= '0;
            timer_flag <= 1'b0;
        end else begin
            if (count_wr) begin
                count <= wdata;
                presc <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
                presc <= '0;
            end else begin
                presc <= presc + 8'd1;
            end
            // A Compare write acknowledges the timer even if a match lands on the same edge.
            if (cmp_wr) begin
                compare    <= wdata;
                timer_flag <= 1'b0;
            end else if (!count_wr && tick && (count + 32'd1 == compare)) begin
                timer_flag <= 1'b1;
            end
        end
    end

    assign timer_irq = timer_flag;
`else
    logic unused_tick_div;
    assign unused_tick_div = (TICK_DIV > 0);
    assign timer_irq       = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_num)
            5'd8:  rdata = bad_vaddr;
`ifdef CP0_TIMER_EN
            5'd9:  rdata = count;
            5'd11: rdata = compare;
`endif
            5'd12: rdata = sr_word;
            5'd13: rdata = cause_word;
            5'd14: rdata = epc;
            5'd15: rdata = PRID;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else begin
            cause_ip <= ip_next;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                epc       <= bd_in ? vpc - 32'd4 : vpc;
                cause_exc <= int_take ? 5'd0 : exc_code_in;
                if (!int_take && (exc_code_in == 5'd4 || exc_code_in == 5'd5))
                    bad_vaddr <= bad_vaddr_in;
            end else begin
                if (eret_in)
                    sr_exl <= 1'b0;
                if (mtc0) begin
                    case (reg_num)
                        5'd12: begin
                            sr_im  <= wdata[10 +: INT_NUM];
                            sr_exl <= wdata[1];
                            sr_ie  <= wdata[0];
                        end
                        5'd14:   epc <= wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_gen.sv
// Self-checking bench for cp0_gen: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural CP0 model.
module tb_cp0_gen;
    localparam int          INT_NUM  = 6;
    localparam logic [31:0] PRID     = 32'h0000_4D50;
    localparam int          TICK_DIV = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               we, eret_in, bd_in;
    logic [4:0]         exc_code_in, reg_num;
    logic [INT_NUM-1:0] int_req;
    logic [31:0]        wdata, vpc, bad_vaddr_in;
    logic [31:0]        rdata, epc_out;
    logic               req, timer_irq;

    always #5 clk = ~clk;

    cp0_gen #(.INT_NUM(INT_NUM), .PRID(PRID), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .reset(reset), .we(we), .eret_in(eret_in), .bd_in(bd_in),
        .exc_code_in(exc_code_in), .reg_num(reg_num), .int_req(int_req),
        .wdata(wdata), .vpc(vpc), .bad_vaddr_in(bad_vaddr_in),
        .rdata(rdata), .epc_out(epc_out), .req(req), .timer_irq(timer_irq)
    );

    int total = 0;
    int bad   = 0;

    // Architectural state of the reference CP0.
    logic [INT_NUM-1:0] m_im, m_ip;
    logic               m_exl, m_ie, m_bd, m_tirq;
    logic [4:0]         m_exc;
    logic [31:0]        m_epc, m_bva, m_count, m_cmp;
    int                 m_pre;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [INT_NUM-1:0] m_ipn();
        logic [INT_NUM-1:0] v;
        v = int_req;
        if (m_tirq) v[INT_NUM-1] = 1'b1;
        return v;
    endfunction

    function automatic logic m_int();
        return ((m_ipn() & m_im) != '0) && m_ie && !m_exl;
    endfunction

    function automatic logic m_exct();
        return (exc_code_in != 5'd0) && !m_exl;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd8:  return m_bva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_cmp;
`endif
            5'd12: return (32'(m_im) << 10) + {30'd0, m_exl, m_ie};
            5'd13: return {m_bd, 31'd0} + (32'(m_ip) << 10) + (32'(m_exc) * 4);
            5'd14: return m_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [INT_NUM-1:0] ipn;
        logic i, e, r;
        if (reset) begin
            m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_tirq = 0;
            m_exc = '0; m_epc = '0; m_bva = '0; m_count = '0; m_cmp = '0; m_pre = 0;
            return;
        end
        ipn = m_ipn(); i = m_int(); e = m_exct(); r = i | e;
`ifdef CP0_TIMER_EN
        begin
            logic cw, pw;
            cw = we && !r && reg_num == 5'd9;
            pw = we && !r && reg_num == 5'd11;
            if (cw) begin
                m_count = wdata; m_pre = 0;
            end else if (m_pre == TICK_DIV - 1) begin
                m_count = m_count + 1; m_pre = 0;
                if (m_count == m_cmp && !pw) m_tirq = 1;
            end else begin
                m_pre++;
            end
            if (pw) begin m_cmp = wdata; m_tirq = 0; end
        end
`endif
        if (r) begin
            m_exl = 1; m_bd = bd_in;
            m_epc = bd_in ? vpc - 32'd4 : vpc;
            m_exc = i ? 5'd0 : exc_code_in;
            if (!i && (exc_code_in == 5'd4 || exc_code_in == 5'd5)) m_bva = bad_vaddr_in;
        end else begin
            if (eret_in) m_exl = 0;
            if (we && reg_num == 5'd12) begin
                m_im = wdata[10 +: INT_NUM]; m_exl = wdata[1]; m_ie = wdata[0];
            end
            if (we && reg_num == 5'd14) m_epc = wdata;
        end
        m_ip = ipn;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model with the DUT edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            chk("req", 32'(req), 32'(m_int() | m_exct()));
            chk("rdata", rdata, m_read(reg_num));
            chk("epc_out", epc_out, (we && reg_num == 5'd14) ? wdata : m_epc);
            chk("timer_irq", 32'(timer_irq), 32'(m_tirq));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; eret_in = 0; bd_in = 0; exc_code_in = 0; reg_num = 0;
        wdata = 0; vpc = 0; bad_vaddr_in = 0;
    endtask

    task automatic lit(input string name, input logic [4:0] r, input logic [31:0] exp);
        reg_num = r;
        #1;
        chk(name, rdata, exp);
        tick();
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        we = 1; reg_num = r; wdata = d;
        tick();
        we = 0;
    endtask

    initial begin
        logic [4:0] regs [9];
        regs = '{5'd0, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        reset = 1; int_req = '0; idle();
        tick(); tick();
        reset = 0;
        chk("req_after_reset", 32'(req), 32'd0);
        lit("rd0_reset", 5'd0, 32'd0);
        lit("badv_reset", 5'd8, 32'd0);
        lit("count_reset", 5'd9, 32'd0);
        lit("cmp_reset", 5'd11, 32'd0);
        lit("sr_reset", 5'd12, 32'd0);
        lit("cause_reset", 5'd13, 32'd0);
        lit("epc_reset", 5'd14, 32'd0);
        lit("prid", 5'd15, PRID);

        // Enabled interrupt taken, then masked by EXL.
        wr(5'd12, 32'h0000_0C01);
        int_req = 6'b000010; vpc = 32'h0000_1000;
        #1 chk("int_req_hit", 32'(req), 32'd1);
        tick();
        vpc = 0;
        lit("sr_exl_set", 5'd12, 32'h0000_0C03);
        chk("req_masked_exl", 32'(req), 32'd0);
        lit("cause_int", 5'd13, 32'h0000_0800);
        lit("epc_int", 5'd14, 32'h0000_1000);
        eret_in = 1; tick(); eret_in = 0;
        vpc = 32'h0000_1100;
        #1 chk("req_after_eret", 32'(req), 32'd1);
        tick();
        eret_in = 1; int_req = '0; vpc = 0; tick(); eret_in = 0;

        // Delay-slot address error with a discarded EPC write.
        exc_code_in = 5'd5; bd_in = 1; vpc = 32'h0000_3010; bad_vaddr_in = 32'h0000_0007;
        we = 1; reg_num = 5'd14; wdata = 32'hDEAD_BEEF;
        #1 chk("exc_req", 32'(req), 32'd1);
        chk("epc_fwd", epc_out, 32'hDEAD_BEEF);
        tick();
        idle();
        lit("epc_bd", 5'd14, 32'h0000_300C);
        lit("cause_bd", 5'd13, 32'h8000_0014);
        lit("badvaddr", 5'd8, 32'h0000_0007);
        eret_in = 1; tick(); eret_in = 0;

        // Interrupt beats a simultaneous exception.
        int_req = 6'b000001; exc_code_in = 5'd12; vpc = 32'h0000_2000;
        tick();
        idle(); int_req = '0;
        lit("cause_prio", 5'd13, 32'h0000_0400);
        eret_in = 1; tick(); eret_in = 0;

        // Reset mid-operation swallows the write and the exception.
        reset = 1; we = 1; reg_num = 5'd12; wdata = 32'hFFFF_FFFF; exc_code_in = 5'd3;
        tick();
        reset = 0; idle();
        lit("sr_midreset", 5'd12, 32'd0);
        lit("epc_midreset", 5'd14, 32'd0);

`ifdef CP0_TIMER_EN
        wr(5'd11, 32'd3);
        wr(5'd9, 32'd0);
        for (int k = 0; k < 11; k++) tick();
        chk("tirq_before", 32'(timer_irq), 32'd0);
        tick();
        chk("tirq_rise", 32'(timer_irq), 32'd1);
        lit("count_at_match", 5'd9, 32'd3);
        wr(5'd11, 32'd0);
        chk("tirq_clear", 32'(timer_irq), 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) tick();
        chk("tirq_prewrap", 32'(timer_irq), 32'd0);
        tick();
        chk("tirq_wrap", 32'(timer_irq), 32'd1);
        wr(5'd11, 32'd0);
        wr(5'd9, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) tick();
        wr(5'd11, 32'd0);
        chk("tirq_clear_wins", 32'(timer_irq), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 299) == 0);
            eret_in     = ($urandom_range(0, 7) == 0);
            we          = !eret_in && ($urandom_range(0, 3) == 0);
            reg_num     = regs[$urandom_range(0, 8)];
            exc_code_in = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            int_req     = ($urandom_range(0, 2) == 0) ? INT_NUM'($urandom) : '0;
            bd_in       = 1'($urandom);
            vpc         = $urandom;
            bad_vaddr_in = $urandom;
            wdata       = $urandom;
            if (reg_num == 5'd9 && $urandom_range(0, 1) == 1)
                wdata = m_cmp - 32'($urandom_range(1, 3));
            tick();
        end
        reset = 0; idle(); int_req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
